// File: rtl/lab_clock_by3.sv
// lab_clock_by3: integer clock divider, clk_out = f(clk)/DIVISOR at 50% duty for odd and even DIVISOR.
// Latency: clk_out rises on the first clk posedge after reset is released, then every DIVISOR posedges.
// Backpressure: none; free-running output, no handshake, no enable.
//
// Ports:
//   clk     - source clock; the phase counter and pos_q update on its rising edge,
//             neg_q (odd divisors only) on its falling edge
//   reset   - asynchronous, active-low; forces clk_out low immediately
//   clk_out - divided clock, period DIVISOR*T(clk), 50% duty
module lab_clock_by3 #(
    parameter int DIVISOR = 3
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    // Guarded so an illegal DIVISOR reaches the $error below instead of a zero-width vector.
    localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam bit IS_ODD = (DIVISOR % 2) != 0;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
    // Posedge-register high count. For odd divisors it is one short, and the falling-edge
    // register adds the missing half cycle.
    localparam logic [CNT_W-1:0] HI_CNT = CNT_W'(IS_ODD ? (DIVISOR - 1) / 2 : DIVISOR / 2);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("lab_clock_by3: DIVISOR must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pos_q;
    logic             w_pos_next;

    always_comb begin
        w_cnt_next = (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
        w_pos_next = (w_cnt_next < HI_CNT);
    end

    // The counter resets to its terminal value, so the first posedge after release wraps
    // it to 0. That posedge also raises pos_q, making it the first rising edge of clk_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= CNT_MAX;
            r_pos_q <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_pos_q <= w_pos_next;
        end
    end

    generate
        if (IS_ODD) begin : g_odd
            logic r_neg_q;

            // A half-cycle-delayed copy of pos_q stretches the high phase by half a clk
            // period. pos_q changes only on posedges and neg_q only on negedges, so the
            // two OR inputs never switch together and the OR cannot produce a runt pulse.
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) begin
                    r_neg_q <= 1'b0;
                end else begin
                    r_neg_q <= r_pos_q;
                end
            end

            assign clk_out = r_pos_q | r_neg_q;
        end else begin : g_even
            assign clk_out = r_pos_q;
        end
    endgenerate

endmodule

// File: tb/tb_lab_clock_by3.sv
module tb_lab_clock_by3;

    logic clk = 1'b0;
    logic reset;
    logic clk_out3;
    logic clk_out4;
    logic clk_out5;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed edges of each divided clock: time and new level.
    longint act3_t[$];
    logic   act3_v[$];
    longint act4_t[$];
    logic   act4_v[$];
    longint act5_t[$];
    logic   act5_v[$];

    // Expected edges, queued when reset is released.
    longint exp3_t[$];
    logic   exp3_v[$];
    longint exp4_t[$];
    logic   exp4_v[$];
    longint exp5_t[$];
    logic   exp5_v[$];

    longint p0;

    always #5 clk = ~clk;

    lab_clock_by3 #(.DIVISOR(3)) u_div3 (.clk(clk), .reset(reset), .clk_out(clk_out3));
    lab_clock_by3 #(.DIVISOR(4)) u_div4 (.clk(clk), .reset(reset), .clk_out(clk_out4));
    lab_clock_by3 #(.DIVISOR(5)) u_div5 (.clk(clk), .reset(reset), .clk_out(clk_out5));

    always @(clk_out3) begin act3_t.push_back($time); act3_v.push_back(clk_out3); end
    always @(clk_out4) begin act4_t.push_back($time); act4_v.push_back(clk_out4); end
    always @(clk_out5) begin act5_t.push_back($time); act5_v.push_back(clk_out5); end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Release reset 2 after a negedge, so the first posedge with reset high is 3 later.
    task automatic release_reset();
        @(negedge clk);
        #2;
        act3_t.delete(); act3_v.delete();
        act4_t.delete(); act4_v.delete();
        act5_t.delete(); act5_v.delete();
        reset = 1'b1;
        p0 = $time + 3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({clk_out5, clk_out4, clk_out3} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_t0: clk_out{5,4,3}=%b required 000", {clk_out5, clk_out4, clk_out3});
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({clk_out5, clk_out4, clk_out3} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold_pos: clk_out{5,4,3}=%b required 000 at %0t",
                         {clk_out5, clk_out4, clk_out3}, $time);
            end
            @(negedge clk); #1;
            n_cmp++;
            if ({clk_out5, clk_out4, clk_out3} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold_neg: clk_out{5,4,3}=%b required 000 at %0t",
                         {clk_out5, clk_out4, clk_out3}, $time);
            end
        end
    endtask

    // Release reset, queue the ideal edge list of every divider over the window, then run it.
    task automatic run_window(input longint dur);
        longint t_end;
        release_reset();
        t_end = $time + dur;
        exp3_t.delete(); exp3_v.delete();
        exp4_t.delete(); exp4_v.delete();
        exp5_t.delete(); exp5_v.delete();
        for (longint t = p0; t < t_end; t += 30) begin
            exp3_t.push_back(t); exp3_v.push_back(1'b1);
            if (t + 15 < t_end) begin exp3_t.push_back(t + 15); exp3_v.push_back(1'b0); end
        end
        for (longint t = p0; t < t_end; t += 40) begin
            exp4_t.push_back(t); exp4_v.push_back(1'b1);
            if (t + 20 < t_end) begin exp4_t.push_back(t + 20); exp4_v.push_back(1'b0); end
        end
        for (longint t = p0; t < t_end; t += 50) begin
            exp5_t.push_back(t); exp5_v.push_back(1'b1);
            if (t + 25 < t_end) begin exp5_t.push_back(t + 25); exp5_v.push_back(1'b0); end
        end
        #(dur);
    endtask

    task automatic test_div3_steady();
        longint et, at;
        logic   ev, av;
        while (exp3_t.size() > 0) begin
            et = exp3_t.pop_front();
            ev = exp3_v.pop_front();
            n_cmp++;
            if (act3_t.size() == 0) begin
                n_bad++;
                $display("FAIL div3_edge: no edge seen, required level %0d at %0d", ev, et);
            end else begin
                at = act3_t.pop_front();
                av = act3_v.pop_front();
                if (at != et || av !== ev) begin
                    n_bad++;
                    $display("FAIL div3_edge: level %0d at %0d, required level %0d at %0d", av, at, ev, et);
                end
            end
        end
        n_cmp++;
        if (act3_t.size() != 0) begin
            n_bad++;
            $display("FAIL div3_extra: %0d unexpected edges, required 0", act3_t.size());
        end
    endtask

    task automatic test_div4_even();
        longint et, at;
        logic   ev, av;
        while (exp4_t.size() > 0) begin
            et = exp4_t.pop_front();
            ev = exp4_v.pop_front();
            n_cmp++;
            if (act4_t.size() == 0) begin
                n_bad++;
                $display("FAIL div4_edge: no edge seen, required level %0d at %0d", ev, et);
            end else begin
                at = act4_t.pop_front();
                av = act4_v.pop_front();
                if (at != et || av !== ev) begin
                    n_bad++;
                    $display("FAIL div4_edge: level %0d at %0d, required level %0d at %0d", av, at, ev, et);
                end
            end
        end
        n_cmp++;
        if (act4_t.size() != 0) begin
            n_bad++;
            $display("FAIL div4_extra: %0d unexpected edges, required 0", act4_t.size());
        end
    endtask

    task automatic test_div5_odd();
        longint et, at;
        logic   ev, av;
        // Every pulse (high or low) must be at least 25 wide: no runt pulses on the OR output.
        for (int i = 1; i < act5_t.size(); i++) begin
            n_cmp++;
            if (act5_t[i] - act5_t[i-1] < 25) begin
                n_bad++;
                $display("FAIL div5_width: pulse of %0d ending at %0d, required >= 25",
                         act5_t[i] - act5_t[i-1], act5_t[i]);
            end
        end
        while (exp5_t.size() > 0) begin
            et = exp5_t.pop_front();
            ev = exp5_v.pop_front();
            n_cmp++;
            if (act5_t.size() == 0) begin
                n_bad++;
                $display("FAIL div5_edge: no edge seen, required level %0d at %0d", ev, et);
            end else begin
                at = act5_t.pop_front();
                av = act5_v.pop_front();
                if (at != et || av !== ev) begin
                    n_bad++;
                    $display("FAIL div5_edge: level %0d at %0d, required level %0d at %0d", av, at, ev, et);
                end
            end
        end
        n_cmp++;
        if (act5_t.size() != 0) begin
            n_bad++;
            $display("FAIL div5_extra: %0d unexpected edges, required 0", act5_t.size());
        end
    endtask

    // Count posedges from release (0,1,2,...): each divider must rise exactly at multiples of its divisor.
    task automatic test_first_edge(input string tag);
        logic [2:0] exp_rise[$];
        logic [2:0] prev, cur, rose, er;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        for (int n = 0; n < 12; n++) begin
            exp_rise.push_back({(n % 5) == 0, (n % 4) == 0, (n % 3) == 0});
        end
        prev = {clk_out5, clk_out4, clk_out3};
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            cur  = {clk_out5, clk_out4, clk_out3};
            rose = cur & ~prev;
            er   = exp_rise.pop_front();
            n_cmp++;
            if (rose !== er) begin
                n_bad++;
                $display("FAIL first_edge_%s: posedge %0d rise{5,4,3}=%b required %b", tag, n, rose, er);
            end
            @(negedge clk); #1;
            prev = {clk_out5, clk_out4, clk_out3};
        end
    endtask

    task automatic test_async_reset();
        logic   prev3;
        logic   found;
        longint t_drop;
        found = 1'b0;
        @(negedge clk); #1;
        prev3 = clk_out3;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (clk_out3 === 1'b1 && prev3 === 1'b0) begin
                found = 1'b1;
            end else begin
                @(negedge clk); #1;
                prev3 = clk_out3;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL async_find_rise: no clk_out3 rise within 20 cycles, required one");
        end else begin
            #4;
            act3_t.delete(); act3_v.delete();
            t_drop = $time;
            reset = 1'b0;
            #1;
            n_cmp++;
            if ({clk_out5, clk_out4, clk_out3} !== 3'b000) begin
                n_bad++;
                $display("FAIL async_drop: clk_out{5,4,3}=%b required 000", {clk_out5, clk_out4, clk_out3});
            end
            n_cmp++;
            if (act3_t.size() == 0) begin
                n_bad++;
                $display("FAIL async_drop_time: no falling edge seen, required fall at %0d", t_drop);
            end else if (act3_t[0] != t_drop || act3_v[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL async_drop_time: level %0d at %0d, required level 0 at %0d",
                         act3_v[0], act3_t[0], t_drop);
            end
            repeat (2) begin
                @(posedge clk); #1;
                n_cmp++;
                if ({clk_out5, clk_out4, clk_out3} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL async_hold: clk_out{5,4,3}=%b required 000 at %0t",
                             {clk_out5, clk_out4, clk_out3}, $time);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        run_window(500);
        test_div3_steady();
        test_div4_even();
        test_div5_odd();
        test_first_edge("power_up");
        test_async_reset();
        test_first_edge("after_async");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
